muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multi-cycle multiply/divide controller owning all writes to the Hi/Lo register pair. Sits beside the EX-stage ALU: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs radix-2 iterations over many cycles. Issues the single-cycle HiLo write and holds the pipeline while a result is pending. The ALU keeps its combinational paths; Hi/Lo writes are removed from it and owned here.

Parameters:
WIDTH, 32, operand width; Hi/Lo are each WIDTH bits
ITER, WIDTH, iteration count per mul/div (one bit per cycle)

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-low reset
Start  in  1  EX holds a valid mul/div/mthi/mtlo this cycle
Op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others ignored
A  in  WIDTH  forwarded rs operand
B  in  WIDTH  forwarded rt operand
ReadReq  in  1  EX holds MFHI/MFLO this cycle
HiLoRead  in  2*WIDTH  current {Hi,Lo} from HiLo register
Busy  out  1  operation accepted and HiLo write not yet issued
Stall  out  1  freeze IF/ID/EX this cycle
HiLoEn  out  1  one-cycle write strobe to HiLo register
HiLoWrite  out  2*WIDTH  {Hi,Lo} write data
Done  out  1  one-cycle completion pulse, coincident with HiLoEn

Behaviour:
- Reset (Reset=0 at an edge): state IDLE, counter 0, Busy=0, HiLoEn=0, Done=0, HiLoWrite=0, internal regs 0. Reset mid-operation aborts with no HiLo write.
- States: IDLE, RUN, FIX, WRITE.
- IDLE: Start=1 with a valid Op is accepted at edge E0.
  - MUL/DIV: latch |A|, |B| (magnitudes for signed ops, raw for unsigned), latch sign flags, go to RUN with counter=0.
  - MTHI/MTLO: go directly to WRITE with HiLoWrite={A,HiLoRead[WIDTH-1:0]} or {HiLoRead[2W-1:W],A}.
  - Invalid Op: no effect.
- RUN: one iteration per edge, E1..E32 (counter 0..ITER-1).
  - Multiply: shift-add into 2W accumulator.
  - Divide: restoring shift-subtract producing quotient/remainder.
  - Counter reaching ITER-1 goes to FIX.
- FIX (edge E33):
  - Signed MULT: negate 64-bit product if sign(A)^sign(B).
  - Signed DIV: negate quotient if signs differ; remainder takes sign of dividend.
  - Result registered into HiLoWrite ({Hi=remainder, Lo=quotient} for div; {Hi=product[63:32], Lo=product[31:0]} for mul).
  - Go to WRITE.
- WRITE: HiLoEn=1 and Done=1 for exactly this cycle; HiLo updates at the following edge. Next state IDLE.
- Latency: MUL/DIV strobe in the cycle after E33; Hi/Lo valid from E34. MTHI/MTLO strobe in the cycle after E0.
- Busy=1 in RUN, FIX and WRITE; Busy=0 in IDLE.
- Stall = Busy & (ReadReq | Start), combinational. Start while Busy is neither accepted nor queued; the stalled instruction re-presents and is accepted in the first IDLE cycle. ReadReq in the WRITE cycle stalls; the read proceeds next cycle, seeing updated HiLo.
- Start and ReadReq in the same IDLE cycle cannot occur (single EX slot); if both are asserted, Start wins and ReadReq is ignored.
- Divide by zero (B=0): Lo=all ones, Hi=A (unsigned or signed); no trap, normal latency.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0.
- Operands are latched at acceptance; later changes on A/B have no effect.

Decomposition:
- Package muldiv_pkg: Op encodings (OP_MULT..OP_MTLO), state enum, ITER constant, div-by-zero result constants.
- One sub-module, muldiv_iter_core: a single combinational multiply-step / divide-step (accumulator, partial remainder, quotient bit). The sequencer owns the FSM, counter, sign fixup and output registers.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HiLoEn one cycle after E33, HiLoWrite={0xFFFFFFFE,0x00000001}; Busy high E0..WRITE.
- MULT A=-3 (0xFFFFFFFD), B=7 -> {0xFFFFFFFF,0xFFFFFFEB}. DIV A=-7, B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1).
- DIVU A=100, B=0 -> Lo=0xFFFFFFFF, Hi=100. DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- MULT accepted, ReadReq held from E1 -> Stall=1 through the WRITE cycle, 0 the cycle after; a second Start at E5 is ignored and accepted only once IDLE.
- MTHI A=0x12345678 with HiLoRead={0,0xAAAA5555} -> HiLoEn the cycle after E0, HiLoWrite={0x12345678,0xAAAA5555}; MFHI next cycle stalls one cycle.
- Reset=0 at E10 of a DIV -> IDLE, Busy=0, no HiLoEn ever; a new MULTU 2x3 afterwards -> {0,6}.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the Hi/Lo multiply/divide sequencer.
// Contents: op encodings, FSM state enum, default width/iteration count,
// divide-by-zero quotient fill, and a signed-op decode helper.
package muldiv_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_ITER  = DEFAULT_WIDTH;

    // EX-stage operation encodings; 110/111 are ignored
    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIX   = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    // Quotient on divide-by-zero is all ones; remainder is the dividend
    localparam logic DIV0_QUOT_BIT = 1'b1;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One radix-2 iteration, purely combinational.
// acc holds {hi, lo}:
//   multiply: hi = partial product, lo = remaining multiplier bits
//   divide:   hi = partial remainder, lo = dividend bits shifting out / quotient bits shifting in
// Ports:
//   is_div   in   select divide step (1) or multiply step (0)
//   acc      in   current 2*WIDTH accumulator
//   operand  in   multiplicand or divisor magnitude
//   acc_next out  accumulator after one step
module muldiv_iter_core
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        hi      = acc[2*WIDTH-1:WIDTH];
        lo      = acc[WIDTH-1:0];
        // Multiply: conditional add, then shift the (WIDTH+1)-bit sum down into lo
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
        // Divide: bring next dividend bit into the remainder; remainder < divisor
        // always holds, so the difference fits in WIDTH bits
        partial = {hi, lo[WIDTH-1]};
        ge      = (partial >= {1'b0, operand});
        diff    = partial[WIDTH-1:0] - operand;
        if (is_div) begin
            acc_next = {(ge ? diff : partial[WIDTH-1:0]), lo[WIDTH-2:0], ge};
        end else begin
            acc_next = {sum, lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide controller that owns every Hi/Lo write.
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, iterates one bit per cycle,
// applies sign fixup, then issues a single-cycle HiLo write strobe.
// Ports:
//   Clock     in   rising-edge clock
//   Reset     in   synchronous active-low reset
//   Start     in   valid mul/div/mthi/mtlo in EX
//   Op        in   operation code (muldiv_pkg::op_e)
//   A, B      in   forwarded rs / rt operands
//   ReadReq   in   MFHI/MFLO in EX
//   HiLoRead  in   current {Hi,Lo}
//   Busy      out  operation in flight (RUN/FIX/WRITE)
//   Stall     out  combinational pipeline freeze
//   HiLoEn    out  one-cycle HiLo write strobe
//   HiLoWrite out  {Hi,Lo} write data
//   Done      out  completion pulse, coincident with HiLoEn
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned ITER  = WIDTH
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [2:0]         Op,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               ReadReq,
    input  logic [2*WIDTH-1:0] HiLoRead,
    output logic               Busy,
    output logic               Stall,
    output logic               HiLoEn,
    output logic [2*WIDTH-1:0] HiLoWrite,
    output logic               Done
);

    localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    state_e             state_q,      state_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [2*WIDTH-1:0] acc_q,        acc_d;
    logic [WIDTH-1:0]   opnd_q,       opnd_d;
    logic               is_div_q,     is_div_d;
    logic               neg_res_q,    neg_res_d;
    logic               neg_rem_q,    neg_rem_d;
    logic               div0_q,       div0_d;
    logic               busy_q,       busy_d;
    logic               hilo_en_q,    hilo_en_d;
    logic               done_q,       done_d;
    logic [2*WIDTH-1:0] hilo_write_q, hilo_write_d;

    logic [2*WIDTH-1:0] acc_step;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    muldiv_iter_core #(
        .WIDTH (WIDTH)
    ) u_iter_core (
        .is_div   (is_div_q),
        .acc      (acc_step_src()),
        .operand  (opnd_q),
        .acc_next (acc_step)
    );

    function automatic logic [2*WIDTH-1:0] acc_step_src();
        return acc_q;
    endfunction

    // State and datapath registers
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            opnd_q       <= '0;
            is_div_q     <= 1'b0;
            neg_res_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            div0_q       <= 1'b0;
            busy_q       <= 1'b0;
            hilo_en_q    <= 1'b0;
            done_q       <= 1'b0;
            hilo_write_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            opnd_q       <= opnd_d;
            is_div_q     <= is_div_d;
            neg_res_q    <= neg_res_d;
            neg_rem_q    <= neg_rem_d;
            div0_q       <= div0_d;
            busy_q       <= busy_d;
            hilo_en_q    <= hilo_en_d;
            done_q       <= done_d;
            hilo_write_q <= hilo_write_d;
        end
    end

    // Next-state, operand capture and sign fixup
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        opnd_d       = opnd_q;
        is_div_d     = is_div_q;
        neg_res_d    = neg_res_q;
        neg_rem_d    = neg_rem_q;
        div0_d       = div0_q;
        hilo_write_d = hilo_write_q;

        a_neg = op_is_signed(Op) & A[WIDTH-1];
        b_neg = op_is_signed(Op) & B[WIDTH-1];
        a_mag = a_neg ? -A : A;
        b_mag = b_neg ? -B : B;

        prod_fix = neg_res_q ? -acc_q : acc_q;
        quot     = acc_q[WIDTH-1:0];
        rem      = acc_q[2*WIDTH-1:WIDTH];
        // Divide-by-zero bypasses quotient negation; remainder fixup still
        // restores the signed dividend into Hi
        quot_fix = div0_q ? {WIDTH{DIV0_QUOT_BIT}} : (neg_res_q ? -quot : quot);
        rem_fix  = neg_rem_q ? -rem : rem;

        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    unique case (Op)
                        OP_MULT, OP_MULTU: begin
                            acc_d     = {{WIDTH{1'b0}}, b_mag};
                            opnd_d    = a_mag;
                            is_div_d  = 1'b0;
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = 1'b0;
                            div0_d    = 1'b0;
                            cnt_d     = '0;
                            state_d   = ST_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            acc_d     = {{WIDTH{1'b0}}, a_mag};
                            opnd_d    = b_mag;
                            is_div_d  = 1'b1;
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            div0_d    = (B == '0);
                            cnt_d     = '0;
                            state_d   = ST_RUN;
                        end
                        OP_MTHI: begin
                            hilo_write_d = {A, HiLoRead[WIDTH-1:0]};
                            state_d      = ST_WRITE;
                        end
                        OP_MTLO: begin
                            hilo_write_d = {HiLoRead[2*WIDTH-1:WIDTH], A};
                            state_d      = ST_WRITE;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                hilo_write_d = is_div_q ? {rem_fix, quot_fix} : prod_fix;
                state_d      = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d    = (state_d != ST_IDLE);
        hilo_en_d = (state_d == ST_WRITE);
        done_d    = (state_d == ST_WRITE);
    end

    assign Busy      = busy_q;
    assign HiLoEn    = hilo_en_q;
    assign Done      = done_q;
    assign HiLoWrite = hilo_write_q;
    // Freeze EX while a result is pending and EX wants Hi/Lo or the unit
    assign Stall     = busy_q & (ReadReq | Start);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;

    localparam int unsigned W = 32;

    logic           Clock;
    logic           Reset;
    logic           Start;
    logic [2:0]     Op;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           ReadReq;
    logic [2*W-1:0] HiLoRead;
    logic           Busy;
    logic           Stall;
    logic           HiLoEn;
    logic [2*W-1:0] HiLoWrite;
    logic           Done;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_sequencer #(.WIDTH(W), .ITER(W)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .ReadReq   (ReadReq),
        .HiLoRead  (HiLoRead),
        .Busy      (Busy),
        .Stall     (Stall),
        .HiLoEn    (HiLoEn),
        .HiLoWrite (HiLoWrite),
        .Done      (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Issue one op at E0, scramble operands afterwards, wait (bounded) for the strobe
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic [2*W-1:0] res,
                          output logic busy_ok, output logic done_ok, output logic idle_after);
        Start = 1'b1; Op = op; A = a; B = b;
        step();
        busy_ok = Busy;
        Start = 1'b0; A = ~a; B = ~b;
        lat = 0;
        while (HiLoEn !== 1'b1 && lat < 100) begin
            step();
            lat++;
            if (Busy !== 1'b1) busy_ok = 1'b0;
        end
        res     = HiLoWrite;
        done_ok = Done;
        HiLoRead = res;
        step();
        idle_after = (Busy === 1'b0) && (HiLoEn === 1'b0) && (Done === 1'b0);
    endtask

    task automatic test_reset();
        Reset = 1'b0; Start = 1'b1; Op = 3'b000; A = 32'd5; B = 32'd5; ReadReq = 1'b1;
        HiLoRead = '0;
        step(); step();
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
        n_cmp++; if (HiLoEn !== 1'b0) begin n_bad++; $display("FAIL reset_hiloen: got %b want 0", HiLoEn); end
        n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", Done); end
        n_cmp++; if (HiLoWrite !== 64'd0) begin n_bad++; $display("FAIL reset_write: got %h want 0", HiLoWrite); end
        n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", Stall); end
        Start = 1'b0; ReadReq = 1'b0;
        Reset = 1'b1;
        step();
    endtask

    task automatic test_multu();
        int lat; logic [2*W-1:0] res; logic bo, dn, ia;
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, bo, dn, ia);
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL multu_latency: got %0d want 33", lat); end
        n_cmp++; if (res !== 64'hFFFF_FFFE_0000_0001) begin n_bad++; $display("FAIL multu_result: got %h want fffffffe00000001", res); end
        n_cmp++; if (bo !== 1'b1) begin n_bad++; $display("FAIL multu_busy_held: got %b want 1", bo); end
        n_cmp++; if (dn !== 1'b1) begin n_bad++; $display("FAIL multu_done_with_en: got %b want 1", dn); end
        n_cmp++; if (ia !== 1'b1) begin n_bad++; $display("FAIL multu_idle_after: got %b want 1", ia); end
    endtask

    task automatic test_signed();
        int lat; logic [2*W-1:0] res; logic bo, dn, ia;
        run_op(3'b000, 32'hFFFF_FFFD, 32'd7, lat, res, bo, dn, ia);
        n_cmp++; if (res !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_bad++; $display("FAIL mult_neg: got %h want ffffffffffffffeb", res); end
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, lat, res, bo, dn, ia);
        n_cmp++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_bad++; $display("FAIL div_neg: got %h want fffffffffffffffd", res); end
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL div_latency: got %0d want 33", lat); end
        run_op(3'b011, 32'd1000, 32'd7, lat, res, bo, dn, ia);
        n_cmp++; if (res !== {32'd6, 32'd142}) begin n_bad++; $display("FAIL divu_basic: got %h want 000000060000008e", res); end
    endtask

    task automatic test_div_edges();
        int lat; logic [2*W-1:0] res; logic bo, dn, ia;
        run_op(3'b011, 32'd100, 32'd0, lat, res, bo, dn, ia);
        n_cmp++; if (res !== {32'd100, 32'hFFFF_FFFF}) begin n_bad++; $display("FAIL divu_by_zero: got %h want 00000064ffffffff", res); end
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL div0_latency: got %0d want 33", lat); end
        run_op(3'b010, 32'hFFFF_FF9C, 32'd0, lat, res, bo, dn, ia);
        n_cmp++; if (res !== 64'hFFFF_FF9C_FFFF_FFFF) begin n_bad++; $display("FAIL div_signed_by_zero: got %h want ffffff9cffffffff", res); end
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, bo, dn, ia);
        n_cmp++; if (res !== 64'h0000_0000_8000_0000) begin n_bad++; $display("FAIL div_overflow: got %h want 0000000080000000", res); end
    endtask

    task automatic test_stall_and_retry();
        int lat; int bad_stall; logic [2*W-1:0] res;
        Start = 1'b1; Op = 3'b000; A = 32'd5; B = 32'd6;
        step();
        n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL stall_accept_busy: got %b want 1", Busy); end
        Start = 1'b0; ReadReq = 1'b1;
        #1;
        bad_stall = (Stall !== 1'b1) ? 1 : 0;
        lat = 0;
        res = '0;
        while (lat < 100) begin
            @(posedge Clock); #1;
            lat++;
            if (lat == 4) begin
                Start = 1'b1; Op = 3'b001; A = 32'd2; B = 32'd3;
            end
            #1;
            if (Stall !== 1'b1) bad_stall++;
            if (HiLoEn === 1'b1) begin
                res = HiLoWrite;
                break;
            end
        end
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL stall_first_latency: got %0d want 33", lat); end
        n_cmp++; if (res !== {32'd0, 32'd30}) begin n_bad++; $display("FAIL stall_first_result: got %h want 000000000000001e", res); end
        n_cmp++; if (bad_stall != 0) begin n_bad++; $display("FAIL stall_held: got %0d unstalled cycles want 0", bad_stall); end
        step();
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL stall_idle_gap_busy: got %b want 0", Busy); end
        n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL stall_released: got %b want 0", Stall); end
        ReadReq = 1'b0;
        step();
        n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL retry_accepted: got %b want 1", Busy); end
        Start = 1'b0;
        lat = 0;
        while (HiLoEn !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL retry_latency: got %0d want 33", lat); end
        n_cmp++; if (HiLoWrite !== {32'd0, 32'd6}) begin n_bad++; $display("FAIL retry_result: got %h want 0000000000000006", HiLoWrite); end
        step();
    endtask

    task automatic test_moves();
        HiLoRead = {32'd0, 32'hAAAA_5555};
        Start = 1'b1; Op = 3'b100; A = 32'h1234_5678;
        step();
        n_cmp++; if (HiLoEn !== 1'b1) begin n_bad++; $display("FAIL mthi_strobe: got %b want 1", HiLoEn); end
        n_cmp++; if (HiLoWrite !== 64'h1234_5678_AAAA_5555) begin n_bad++; $display("FAIL mthi_data: got %h want 12345678aaaa5555", HiLoWrite); end
        n_cmp++; if (Done !== 1'b1) begin n_bad++; $display("FAIL mthi_done: got %b want 1", Done); end
        Start = 1'b0; ReadReq = 1'b1;
        #1;
        n_cmp++; if (Stall !== 1'b1) begin n_bad++; $display("FAIL mfhi_stall: got %b want 1", Stall); end
        HiLoRead = 64'h1234_5678_AAAA_5555;
        step();
        n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL mfhi_proceeds: got %b want 0", Stall); end
        n_cmp++; if (HiLoEn !== 1'b0) begin n_bad++; $display("FAIL mthi_one_cycle: got %b want 0", HiLoEn); end
        ReadReq = 1'b0;
        Start = 1'b1; Op = 3'b101; A = 32'hDEAD_BEEF;
        step();
        n_cmp++; if (HiLoWrite !== 64'h1234_5678_DEAD_BEEF) begin n_bad++; $display("FAIL mtlo_data: got %h want 12345678deadbeef", HiLoWrite); end
        Start = 1'b0;
        step();
        Start = 1'b1; Op = 3'b110; A = 32'h5555_0000;
        step();
        n_cmp++; if (Busy !== 1'b0 || HiLoEn !== 1'b0) begin n_bad++; $display("FAIL invalid_op: got busy=%b en=%b want 0 0", Busy, HiLoEn); end
        Start = 1'b0;
        step();
    endtask

    task automatic test_reset_abort();
        int lat; logic [2*W-1:0] res; logic bo, dn, ia;
        logic en_seen; logic busy_seen;
        Start = 1'b1; Op = 3'b010; A = 32'd1000; B = 32'd7;
        step();
        Start = 1'b0;
        en_seen = 1'b0;
        for (int k = 1; k < 10; k++) begin
            step();
            en_seen = en_seen | HiLoEn;
        end
        Reset = 1'b0;
        step();
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", Busy); end
        Reset = 1'b1;
        busy_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            en_seen   = en_seen | HiLoEn;
            busy_seen = busy_seen | Busy;
        end
        n_cmp++; if (en_seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_write: got %b want 0", en_seen); end
        n_cmp++; if (busy_seen !== 1'b0) begin n_bad++; $display("FAIL abort_stays_idle: got %b want 0", busy_seen); end
        run_op(3'b001, 32'd2, 32'd3, lat, res, bo, dn, ia);
        n_cmp++; if (res !== {32'd0, 32'd6}) begin n_bad++; $display("FAIL after_abort_multu: got %h want 0000000000000006", res); end
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL after_abort_latency: got %0d want 33", lat); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_signed();
        test_div_edges();
        test_stall_and_retry();
        test_moves();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
